// File: rtl/encoder_8x3_queued.sv
// rtl/encoder_8x3_queued.sv - 8-line request capture queue emitting one 3-bit code per handshake
//
// Purpose:
//   Collects up to eight request lines into a pending mask and serves them one
//   at a time as a 3-bit index {a,b,c} (a = MSB) under a valid/ready handshake.
//   Feeding {a,b,c} into a 3x8 decoder with en=valid regenerates the served line.
//
// Parameters:
//   ROUND_ROBIN  0: fixed priority, d[7] highest.
//                1: rotating priority, the search starts just below the last
//                   served index and wraps 0 -> 7.
//
// Ports:
//   clk      in   1  rising-edge clock
//   rst      in   1  asynchronous active-high reset
//   en       in   1  capture enable for d
//   d        in   8  request lines, level-sampled while en=1
//   ready    in   1  consumer accepts {a,b,c} when valid=1
//   clr_ovf  in   1  synchronous clear of ovf
//   a,b,c    out  1  registered code bits 2..0
//   valid    out  1  {a,b,c} holds a pending request index
//   ovf      out  1  sticky: a request hit an already-pending line
//   pend     out  8  registered pending mask

module encoder_8x3_queued #(
  parameter bit ROUND_ROBIN = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] d,
  input  logic       ready,
  input  logic       clr_ovf,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       valid,
  output logic       ovf,
  output logic [7:0] pend
);

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] pend_q, pend_d;
  logic [2:0] code_q, code_d;
  logic [2:0] last_q, last_d;
  logic       valid_q, valid_d;
  logic       ovf_q, ovf_d;

  logic       accept;
  logic [7:0] clr_mask;
  logic [7:0] cap_mask;
  logic       ovf_set;

  logic [2:0] start_idx;
  logic [2:0] probe_idx;
  logic [2:0] sel_idx;
  logic       sel_found;

  // Pending mask and overflow. A bit captured on the same edge as its own
  // accept survives the clear, and that collision is not an overflow.
  always_comb begin
    accept   = valid_q & ready;
    clr_mask = accept ? (8'd1 << code_q) : 8'd0;
    cap_mask = en ? d : 8'd0;
    pend_d   = (pend_q & ~clr_mask) | cap_mask;
    ovf_set  = |(cap_mask & pend_q & ~clr_mask);
    ovf_d    = ovf_set | (ovf_q & ~clr_ovf);
  end

  // Downward search over the registered mask. Fixed priority is simply a
  // search that always starts at 7; round-robin starts one below last_q,
  // so last_q=0 after reset makes the first search start at 7 as well.
  always_comb begin
    start_idx = ROUND_ROBIN ? (last_q - 3'd1) : 3'd7;
    probe_idx = 3'd0;
    sel_idx   = 3'd0;
    sel_found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      probe_idx = start_idx - 3'(k);
      if (!sel_found && pend_q[probe_idx]) begin
        sel_idx   = probe_idx;
        sel_found = 1'b1;
      end
    end
  end

  // Output FSM. IDLE always costs one cycle after an accept, which caps
  // throughput at one code every two clocks.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    valid_d = valid_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (sel_found) begin
          code_d  = sel_idx;
          valid_d = 1'b1;
          state_d = SERVE;
        end
      end
      SERVE: begin
        if (ready) begin
          last_d  = code_q;
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= 8'd0;
      code_q  <= 3'd0;
      last_q  <= 3'd0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      code_q  <= code_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign a     = code_q[2];
  assign b     = code_q[1];
  assign c     = code_q[0];
  assign valid = valid_q;
  assign ovf   = ovf_q;
  assign pend  = pend_q;

endmodule

// File: tb/tb_encoder_8x3_queued.sv
// tb/tb_encoder_8x3_queued.sv - scoreboard bench for encoder_8x3_queued, fixed and round-robin instances

`timescale 1ns/1ps

module tb_encoder_8x3_queued;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] d;
  logic       ready;
  logic       clr_ovf;

  logic       a0, b0, c0, valid0, ovf0;
  logic [7:0] pend0;
  logic       a1, b1, c1, valid1, ovf1;
  logic [7:0] pend1;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state: [0] fixed priority, [1] round robin
  bit m_pend [2][8];
  bit m_valid[2];
  int m_code [2];
  int m_last [2];
  bit m_ovf  [2];

  int exp_q0[$];
  int exp_q1[$];
  int acc0[$];
  int acc1[$];

  always #5 clk = ~clk;

  encoder_8x3_queued #(.ROUND_ROBIN(1'b0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .d(d), .ready(ready), .clr_ovf(clr_ovf),
    .a(a0), .b(b0), .c(c0), .valid(valid0), .ovf(ovf0), .pend(pend0)
  );

  encoder_8x3_queued #(.ROUND_ROBIN(1'b1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .d(d), .ready(ready), .clr_ovf(clr_ovf),
    .a(a1), .b(b1), .c(c1), .valid(valid1), .ovf(ovf1), .pend(pend1)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Highest pending line, or for round robin the first pending line found
  // walking down from one below the last served line.
  function automatic int choose(input int j);
    int idx;
    if (j == 0) begin
      for (int i = 7; i >= 0; i--)
        if (m_pend[0][i]) return i;
    end else begin
      for (int k = 1; k <= 8; k++) begin
        idx = (m_last[1] - k + 16) % 8;
        if (m_pend[1][idx]) return idx;
      end
    end
    return -1;
  endfunction

  task automatic model_step(input int j);
    bit acc;
    bit clr;
    bit hit;
    bit np[8];
    int pick;
    acc = m_valid[j] && (ready === 1'b1);
    hit = 1'b0;
    for (int i = 0; i < 8; i++) begin
      clr = acc && (i == m_code[j]);
      if (en && d[i] && m_pend[j][i] && !clr) hit = 1'b1;
      np[i] = (m_pend[j][i] && !clr) || (en && d[i]);
    end
    if (m_valid[j]) begin
      if (acc) begin
        m_last[j]  = m_code[j];
        m_valid[j] = 1'b0;
      end
    end else begin
      pick = choose(j);
      if (pick >= 0) begin
        m_code[j]  = pick;
        m_valid[j] = 1'b1;
        if (j == 0) exp_q0.push_back(pick);
        else        exp_q1.push_back(pick);
      end
    end
    for (int i = 0; i < 8; i++) m_pend[j][i] = np[i];
    if (hit)          m_ovf[j] = 1'b1;
    else if (clr_ovf) m_ovf[j] = 1'b0;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < 2; j++) begin
        for (int i = 0; i < 8; i++) m_pend[j][i] = 1'b0;
        m_valid[j] = 1'b0;
        m_code[j]  = 0;
        m_last[j]  = 0;
        m_ovf[j]   = 1'b0;
      end
      exp_q0.delete();
      exp_q1.delete();
    end else begin
      model_step(0);
      model_step(1);
    end
  end

  task automatic monitor_one(input int j, input logic v, input logic [2:0] code,
                             input logic [7:0] p, input logic o);
    logic [7:0] ep;
    int e;
    for (int i = 0; i < 8; i++) ep[i] = m_pend[j][i];
    chk($sformatf("dut%0d valid", j), int'(v), int'(m_valid[j]));
    chk($sformatf("dut%0d pend", j), int'(p), int'(ep));
    chk($sformatf("dut%0d ovf", j), int'(o), int'(m_ovf[j]));
    if (m_valid[j]) chk($sformatf("dut%0d code", j), int'(code), m_code[j]);
    if (v === 1'b1 && ready === 1'b1) begin
      if (j == 0) begin
        acc0.push_back(int'(code));
        if (exp_q0.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL dut0 scoreboard: code %0d accepted, none expected", code);
        end else begin
          e = exp_q0.pop_front();
          chk("dut0 accepted code", int'(code), e);
        end
      end else begin
        acc1.push_back(int'(code));
        if (exp_q1.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL dut1 scoreboard: code %0d accepted, none expected", code);
        end else begin
          e = exp_q1.pop_front();
          chk("dut1 accepted code", int'(code), e);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      monitor_one(0, valid0, {a0, b0, c0}, pend0, ovf0);
      monitor_one(1, valid1, {a1, b1, c1}, pend1, ovf1);
    end
  end

  // Inputs set here take effect on the following rising edge.
  task automatic cyc(input bit e, input logic [7:0] dd, input bit r, input bit co);
    @(posedge clk);
    #2;
    en = e; d = dd; ready = r; clr_ovf = co;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; d = 8'h00; ready = 1'b0; clr_ovf = 1'b0;
    #12;
    chk("reset pend", int'(pend0), 0);
    chk("reset valid", int'(valid0), 0);
    chk("reset abc", int'({a0, b0, c0}), 0);
    chk("reset ovf", int'(ovf1), 0);
    rst = 1'b0;

    // reset mid-SERVE, applied between edges
    cyc(1'b1, 8'h24, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    chk("pre-reset valid", int'(valid0), 1);
    chk("pre-reset abc", int'({a0, b0, c0}), 5);
    chk("pre-reset pend", int'(pend1), 8'h24);
    rst = 1'b1;
    #1;
    chk("async reset pend", int'(pend0), 0);
    chk("async reset valid", int'(valid1), 0);
    chk("async reset abc", int'({a1, b1, c1}), 0);
    chk("async reset ovf", int'(ovf0), 0);
    rst = 1'b0;

    // round robin alternation with 0x81 held
    acc1.delete();
    for (int i = 0; i < 9; i++) cyc(1'b1, 8'h81, 1'b1, 1'b0);
    drain(8);
    chk("rr accept count", acc1.size() >= 4 ? 1 : 0, 1);
    if (acc1.size() >= 4) begin
      chk("rr code 0", acc1[0], 7);
      chk("rr code 1", acc1[1], 0);
      chk("rr code 2", acc1[2], 7);
      chk("rr code 3", acc1[3], 0);
    end

    // fixed priority order 7, 4, 1
    acc0.delete();
    cyc(1'b1, 8'h92, 1'b1, 1'b1);
    drain(8);
    chk("fixed accept count", acc0.size(), 3);
    if (acc0.size() == 3) begin
      chk("fixed code 0", acc0[0], 7);
      chk("fixed code 1", acc0[1], 4);
      chk("fixed code 2", acc0[2], 1);
    end

    // backpressure
    cyc(1'b1, 8'h08, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("stall valid", int'(valid0), 1);
    chk("stall abc", int'({a1, b1, c1}), 3);
    chk("stall pend", int'(pend0), 8'h08);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("post-accept valid", int'(valid1), 0);
    chk("post-accept pend", int'(pend0), 0);

    // overflow, then set/clear collision on the accept edge
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    cyc(1'b1, 8'h04, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b1, 8'h04, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("ovf set", int'(ovf0), 1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("ovf cleared", int'(ovf1), 0);
    cyc(1'b1, 8'h04, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("collide ovf", int'(ovf0), 0);
    chk("collide pend", int'(pend1), 8'h04);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("re-emit valid", int'(valid0), 1);
    chk("re-emit abc", int'({a0, b0, c0}), 2);
    drain(6);

    // en gating
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'hFF, 1'b1, 1'b0);
    cyc(1'b1, 8'hFF, 1'b0, 1'b0);
    chk("gated pend", int'(pend0), 0);
    chk("gated valid", int'(valid0), 0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("capture pend", int'(pend0), 8'hFF);
    chk("capture valid", int'(valid0), 0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("first code", int'({a0, b0, c0}), 7);
    drain(24);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      cyc($urandom_range(0, 3) != 0, 8'($urandom & $urandom),
          $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0);
    end
    drain(40);
    @(negedge clk);
    #1;
    chk("dut0 queue empty", exp_q0.size(), 0);
    chk("dut1 queue empty", exp_q1.size(), 0);
    chk("dut0 idle at end", int'(valid0), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
